// File: rtl/uart_cmd_ctrl.sv
// Parses 4-byte HEADER/ADDR/DATA/CHK write frames from UART byte strobes into a 16x8 register file.
// Commit/drop pulses one cycle after the deciding byte; no back-pressure, stalled frames time out.
module uart_cmd_ctrl #(
    parameter int         TIMEOUT_CYCLES = 208320,
    parameter logic [7:0] HEADER         = 8'hAA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       wr_en,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err,
    output logic [7:0] err_cnt,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, GET_ADDR, GET_DATA, GET_CHK} state_t;

    // Terminal compare is one below TIMEOUT_CYCLES-1 so the drop lands on the
    // edge where the counter would reach TIMEOUT_CYCLES-1.
    localparam logic [17:0] TMO_TERM = 18'(TIMEOUT_CYCLES - 2);

    state_t      state, state_nxt;
    logic [7:0]  regs [16];
    logic [3:0]  addr_q;
    logic [7:0]  data_q;
    logic [17:0] tmo_cnt;
    logic        tmo_hit;
    logic        commit;
    logic        drop;

    // A byte arriving on the terminal cycle takes priority over the timeout.
    assign tmo_hit = (state != IDLE) && !rx_valid && (tmo_cnt == TMO_TERM);
    assign busy    = (state != IDLE);
    assign rd_data = regs[rd_addr];

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid && rx_data == HEADER) state_nxt = GET_ADDR;
            end
            GET_ADDR: begin
                if (rx_valid) begin
                    if (rx_data[7:4] != 4'h0) begin
                        drop      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = GET_DATA;
                    end
                end
            end
            GET_DATA: begin
                if (rx_valid) state_nxt = GET_CHK;
            end
            GET_CHK: begin
                if (rx_valid) begin
                    if (rx_data == ({4'h0, addr_q} ^ data_q)) commit = 1'b1;
                    else                                      drop   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (tmo_hit) begin
            drop      = 1'b1;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= 4'h0;
            data_q    <= 8'h00;
            tmo_cnt   <= 18'd0;
            wr_en     <= 1'b0;
            wr_addr   <= 4'h0;
            wr_data   <= 8'h00;
            frame_err <= 1'b0;
            err_cnt   <= 8'h00;
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
        end else begin
            state     <= state_nxt;
            wr_en     <= commit;
            frame_err <= drop;
            if (state == IDLE || rx_valid || tmo_hit) tmo_cnt <= 18'd0;
            else                                      tmo_cnt <= tmo_cnt + 18'd1;
            if (state == GET_ADDR && rx_valid) addr_q <= rx_data[3:0];
            if (state == GET_DATA && rx_valid) data_q <= rx_data;
            if (commit) begin
                regs[addr_q] <= data_q;
                wr_addr      <= addr_q;
                wr_data      <= data_q;
            end
            if (drop && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: frame vector table plus timeout, tie, saturation and reset sequences.
module tb_uart_cmd_ctrl;

    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;
    logic [7:0] err_cnt;
    logic       busy;

    uart_cmd_ctrl #(.TIMEOUT_CYCLES(TMO), .HEADER(8'hAA)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_err(frame_err), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int         wr_pulses  = 0;
    int         err_pulses = 0;
    logic [3:0] last_wa    = 4'h0;
    logic [7:0] last_wd    = 8'h00;
    logic [7:0] rd_at_wr   = 8'h00;
    logic       busy_at_wr = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                wr_pulses++;
                last_wa    = wr_addr;
                last_wd    = wr_data;
                rd_at_wr   = rd_data;
                busy_at_wr = busy;
            end
            if (frame_err) err_pulses++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        if (gap > 1) begin
            repeat (gap - 1) @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [5:0][7:0] b;
        int              n;
        int              exp_wr;
        int              exp_err;
        logic [3:0]      ra;
        logic [7:0]      rd;
        logic [7:0]      ecnt;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, e0, nz;

        vecs[0] = '{b: {8'h00, 8'h00, 8'h5F, 8'h5C, 8'h03, 8'hAA}, n: 4, exp_wr: 1, exp_err: 0, ra: 4'h3, rd: 8'h5C, ecnt: 8'd0};
        vecs[1] = '{b: {8'h00, 8'h00, 8'h00, 8'h5C, 8'h03, 8'hAA}, n: 4, exp_wr: 0, exp_err: 1, ra: 4'h3, rd: 8'h5C, ecnt: 8'd1};
        vecs[2] = '{b: {8'h00, 8'h00, 8'hFE, 8'hFF, 8'h01, 8'hAA}, n: 4, exp_wr: 1, exp_err: 0, ra: 4'h1, rd: 8'hFF, ecnt: 8'd1};
        vecs[3] = '{b: {8'h0E, 8'h01, 8'h0F, 8'hAA, 8'h22, 8'h11}, n: 6, exp_wr: 1, exp_err: 0, ra: 4'hF, rd: 8'h01, ecnt: 8'd1};
        vecs[4] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'hAA}, n: 2, exp_wr: 0, exp_err: 1, ra: 4'h2, rd: 8'h00, ecnt: 8'd2};

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rd_addr  = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset wr_en", wr_en, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset err_cnt", err_cnt, 0);
        chk("reset busy", busy, 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset wr_addr/wr_data", {wr_addr, wr_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            w0 = wr_pulses;
            e0 = err_pulses;
            rd_addr = vecs[v].ra;
            for (int j = 0; j < vecs[v].n; j++) send(vecs[v].b[j], 20);
            chk($sformatf("v%0d wr pulses", v), wr_pulses - w0, vecs[v].exp_wr);
            chk($sformatf("v%0d err pulses", v), err_pulses - e0, vecs[v].exp_err);
            chk($sformatf("v%0d rd_data", v), rd_data, vecs[v].rd);
            chk($sformatf("v%0d err_cnt", v), err_cnt, vecs[v].ecnt);
            chk($sformatf("v%0d busy", v), busy, 0);
            if (vecs[v].exp_wr != 0) begin
                chk($sformatf("v%0d wr_addr", v), last_wa, vecs[v].ra);
                chk($sformatf("v%0d wr_data", v), last_wd, vecs[v].rd);
                chk($sformatf("v%0d rd during wr_en", v), rd_at_wr, vecs[v].rd);
                chk($sformatf("v%0d busy during wr_en", v), busy_at_wr, 0);
            end
        end

        // Timeout: frame stalls after ADDR, drop lands TMO-1 cycles later.
        e0 = err_pulses;
        send(8'hAA, 1);
        chk("busy after header", busy, 1);
        send(8'h02, 1);
        repeat (TMO - 2) @(posedge clk);
        #1;
        chk("no early timeout", frame_err, 0);
        chk("busy before timeout", busy, 1);
        @(posedge clk);
        #1;
        chk("timeout frame_err", frame_err, 1);
        chk("timeout busy", busy, 0);
        chk("timeout err_cnt", err_cnt, 3);
        send(8'h5A, 20);
        chk("5A ignored busy", busy, 0);
        chk("5A ignored err", err_pulses - e0, 1);

        // Byte on the terminal cycle wins over the timeout.
        e0 = err_pulses;
        w0 = wr_pulses;
        rd_addr = 4'h2;
        send(8'hAA, 1);
        repeat (TMO - 2) @(posedge clk);
        #1;
        send(8'h02, 1);
        chk("tie busy", busy, 1);
        send(8'h07, 5);
        send(8'h05, 5);
        chk("tie err pulses", err_pulses - e0, 0);
        chk("tie wr pulses", wr_pulses - w0, 1);
        chk("tie rd_data", rd_data, 8'h07);

        // Saturation of the drop counter.
        e0 = err_pulses;
        for (int k = 0; k < 300; k++) begin
            send(8'hAA, 2);
            send(8'h00, 2);
            send(8'h00, 2);
            send(8'h01, 2);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("sat err pulses", err_pulses - e0, 300);
        chk("sat err_cnt", err_cnt, 8'hFF);

        // Reset mid-frame discards the partial frame silently.
        e0 = err_pulses;
        send(8'hAA, 3);
        send(8'h04, 3);
        rst_n = 1'b0;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset err_cnt", err_cnt, 0);
        nz = 0;
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            if (rd_data != 8'h00) nz++;
        end
        chk("midreset regs clear", nz, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        w0 = wr_pulses;
        rd_addr = 4'h4;
        send(8'hAA, 5);
        send(8'h04, 5);
        send(8'h10, 5);
        send(8'h14, 5);
        chk("post-reset wr pulses", wr_pulses - w0, 1);
        chk("post-reset rd_data", rd_data, 8'h10);
        chk("post-reset err pulses", err_pulses - e0, 0);
        chk("post-reset err_cnt", err_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command-frame controller that sits directly behind the UART receiver. It consumes the receiver's one-cycle byte strobes, parses fixed 4-byte write frames, and checks each frame's checksum and inter-byte timeout. Valid frames are committed into a 16×8 configuration register file that the rest of the design reads. Malformed or stalled frames are dropped and counted.

## Interface
- TIMEOUT_CYCLES, default 208320: maximum clk cycles allowed between consecutive bytes of one frame (2 byte-times at 10416 clk/bit).
- HEADER, default 8'hAA: frame start byte.
- clk  in  1  system clock.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- rx_valid  in  1  byte strobe from the UART receiver, one cycle wide; pulses are ≥2 cycles apart.
- rx_data  in  8  received byte; valid only while rx_valid=1.
- rd_addr  in  4  register file read address.
- rd_data  out  8  combinational read of regs[rd_addr].
- wr_en  out  1  one-cycle pulse marking a committed write.
- wr_addr  out  4  address of the last committed write; held between writes.
- wr_data  out  8  data of the last committed write; held between writes.
- frame_err  out  1  one-cycle pulse when a frame is dropped.
- err_cnt  out  8  count of dropped frames; saturates at 255.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Frame format: HEADER, ADDR, DATA, CHK.
  - CHK must equal ADDR ^ DATA.
  - ADDR[7:4] must be 0.
- States and transitions, evaluated only on rx_valid unless noted:
  - IDLE: a byte equal to HEADER moves to GET_ADDR. Any other byte is silently ignored: no error, no count.
  - GET_ADDR: if ADDR[7:4]≠0, drop the frame and go to IDLE. Otherwise latch ADDR[3:0] and go to GET_DATA.
  - GET_DATA: latch DATA and go to GET_CHK.
  - GET_CHK: on match, commit the write and go to IDLE. On mismatch, drop the frame and go to IDLE.
- A HEADER-valued byte received in GET_ADDR/GET_DATA/GET_CHK is treated as ordinary frame content; there is no resync.
- Commit: on the same edge, regs[addr]<=data, wr_addr<=addr, wr_data<=data, wr_en<=1.
- Drop: on the same edge, frame_err<=1 and err_cnt<=err_cnt+1 unless it is already 255.
- Timeout counter (18 bits):
  - Cleared in IDLE and on every accepted rx_valid.
  - Increments every cycle otherwise.
  - Reaching TIMEOUT_CYCLES-1 while not IDLE drops the frame and returns to IDLE.
- Simultaneous rx_valid and timeout terminal count: rx_valid wins. The byte is processed and the counter is cleared; no error.
- Reset values:
  - state IDLE, all 16 regs 0, wr_addr 0, wr_data 0.
  - wr_en 0, frame_err 0, err_cnt 0, timeout counter 0.
  - busy 0, and rd_data therefore 0.
- Reset mid-frame discards the partial frame without counting it as an error.

## Timing
- wr_en and frame_err are registered and high for exactly one cycle: the cycle after the rx_valid (or timeout) edge that caused them.
- rd_data reflects the new value in the same cycle wr_en is high.
- busy goes high the cycle after the HEADER byte's rx_valid. It goes low the cycle after commit, drop or timeout.
- Throughput: one frame per 4 received bytes. There is no back-pressure; the receiver cannot be stalled.
- Timeout fires exactly TIMEOUT_CYCLES-1 cycles after the last accepted byte, with no intervening rx_valid.

## Test plan
- Bytes AA,03,5C,5F at 20-cycle spacing:
  - one wr_en pulse with wr_addr=3, wr_data=5C.
  - rd_addr=3 gives rd_data=5C.
  - err_cnt=0, frame_err never asserted.
- Bytes AA,03,5C,00 (bad CHK): no wr_en, one frame_err pulse, err_cnt=1, regs[3] unchanged. Follow with AA,01,FF,FE: regs[1]=FF.
- Bytes 11,22,AA,0F,01,0E (leading garbage): garbage is ignored with no error; regs[F]=01, wr_en pulses once.
- Bytes AA,02, then silence for TIMEOUT_CYCLES (use TIMEOUT_CYCLES=50 in sim): frame_err at cycle 49 after the last byte, busy drops, err_cnt=1. Next byte 5A is ignored as non-header.
- Byte AA,12 (ADDR upper nibble ≠0): immediate frame_err, back to IDLE.
- 300 consecutive bad-CHK frames: err_cnt saturates at FF and does not wrap.
- rst_n pulsed low after AA,04: state IDLE, busy 0, err_cnt 0, all regs 0. Next full frame AA,04,10,14 commits normally.
